// File: rtl/game_pkg.sv
// Shared definitions for the game controller.
//   - game_state_e : TITLE / PLAY / OVER encodings driven on game_state
//   - ANGLE_W, SCORE_W, WEAPON_W, HEALTH_W : output field widths
//   - sat_add()    : saturating score addition, one bit wider than the score
package game_pkg;

   localparam int ANGLE_W  = 4;
   localparam int SCORE_W  = 18;
   localparam int WEAPON_W = 2;
   localparam int HEALTH_W = 3;

   typedef enum logic [1:0] {
      TITLE = 2'd0,
      PLAY  = 2'd1,
      OVER  = 2'd2
   } game_state_e;

   // The sum is formed one bit wider than the score so it cannot wrap
   // before the saturation compare.
   function automatic logic [SCORE_W-1:0] sat_add(
      input logic [SCORE_W-1:0] base,
      input logic [7:0]         points,
      input logic [SCORE_W-1:0] limit
   );
      logic [SCORE_W:0] sum;
      sum = {1'b0, base} + {{(SCORE_W-7){1'b0}}, points};
      return (sum > {1'b0, limit}) ? limit : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces one active-low push button and emits a
// single-cycle press pulse on the debounced 1-to-0 transition.
//   CLK    : system clock
//   RESET  : asynchronous active-low reset (all stages return to released level)
//   btn_n  : raw button, active-low, asynchronous to CLK
//   press  : one-cycle pulse per debounced press
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic btn_n,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic             press_d;

   // Down-counter runs only while the synchronised input disagrees with the
   // debounced level; any agreement reloads it, so only an unbroken run of
   // DEBOUNCE_CYCLES disagreeing cycles reaches terminal count.
   always_comb begin
      level_d = level;
      cnt_d   = CNT_LOAD;
      if (sync2 != level) begin
         if (cnt == '0) begin
            level_d = sync2;
         end else begin
            cnt_d = cnt - 1'b1;
         end
      end
      press_d = level & ~level_d;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= CNT_LOAD;
         press <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         level <= level_d;
         cnt   <= cnt_d;
         press <= press_d;
      end
   end

endmodule

// File: rtl/game_controller.sv
// Game-flow controller: debounces the four player buttons and tracks game
// state, aim angle, weapon, score and health.
//   CLK, RESET                   : pixel clock, async active-low reset
//   Weapon_switch, Rotate_CW,
//   Rotate_CCW, Interaction      : raw active-low buttons
//   hit_valid, hit_points        : enemy destroyed, points to add
//   damage_valid                 : player struck
//   game_state                   : 0=TITLE 1=PLAY 2=OVER
//   angle, weapon, score, health : registered game outputs
//   new_game                     : one-cycle pulse on every entry to PLAY
//
// state | meaning
// TITLE | waiting for Interaction; all other inputs ignored
// PLAY  | rotation, weapon, hit and damage active; Interaction ignored
// OVER  | outputs frozen; Interaction restarts the game
module game_controller
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int MAX_HEALTH      = 3,
   parameter int NUM_WEAPONS     = 3,
   parameter int SCORE_MAX       = 99999
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                Weapon_switch,
   input  logic                Rotate_CW,
   input  logic                Rotate_CCW,
   input  logic                Interaction,
   input  logic                hit_valid,
   input  logic [7:0]          hit_points,
   input  logic                damage_valid,
   output logic [1:0]          game_state,
   output logic [ANGLE_W-1:0]  angle,
   output logic [WEAPON_W-1:0] weapon,
   output logic [SCORE_W-1:0]  score,
   output logic [HEALTH_W-1:0] health,
   output logic                new_game
);

   localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
   localparam logic [WEAPON_W-1:0] WEAPON_LAST = WEAPON_W'(NUM_WEAPONS - 1);
   localparam logic [SCORE_W-1:0]  SCORE_LIMIT = SCORE_W'(SCORE_MAX);

   logic weapon_press;
   logic cw_press;
   logic ccw_press;
   logic int_press;

   game_state_e         state_q;
   game_state_e         state_d;
   logic [ANGLE_W-1:0]  angle_d;
   logic [WEAPON_W-1:0] weapon_d;
   logic [SCORE_W-1:0]  score_d;
   logic [HEALTH_W-1:0] health_d;
   logic                new_game_d;
   logic                start;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_weapon (
      .CLK(CLK), .RESET(RESET), .btn_n(Weapon_switch), .press(weapon_press)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cw (
      .CLK(CLK), .RESET(RESET), .btn_n(Rotate_CW), .press(cw_press)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ccw (
      .CLK(CLK), .RESET(RESET), .btn_n(Rotate_CCW), .press(ccw_press)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_int (
      .CLK(CLK), .RESET(RESET), .btn_n(Interaction), .press(int_press)
   );

   always_comb begin
      state_d    = state_q;
      angle_d    = angle;
      weapon_d   = weapon;
      score_d    = score;
      health_d   = health;
      new_game_d = 1'b0;
      start      = 1'b0;

      case (state_q)
         TITLE: begin
            start = int_press;
         end
         PLAY: begin
            // Opposing rotations in the same cycle cancel.
            if (cw_press && !ccw_press) begin
               angle_d = angle + 1'b1;
            end else if (ccw_press && !cw_press) begin
               angle_d = angle - 1'b1;
            end
            if (weapon_press) begin
               weapon_d = (weapon >= WEAPON_LAST) ? '0 : weapon + 1'b1;
            end
            if (hit_valid) begin
               score_d = sat_add(score, hit_points, SCORE_LIMIT);
            end
            if (damage_valid && (health != '0)) begin
               health_d = health - 1'b1;
            end
            // The final hit's score is committed on the same edge that
            // enters OVER, so a simultaneous hit still counts.
            if (health_d == '0) begin
               state_d = OVER;
            end
         end
         OVER: begin
            start = int_press;
         end
         default: begin
            state_d = TITLE;
         end
      endcase

      if (start) begin
         state_d    = PLAY;
         score_d    = '0;
         health_d   = HEALTH_INIT;
         angle_d    = '0;
         weapon_d   = '0;
         new_game_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= TITLE;
         angle    <= '0;
         weapon   <= '0;
         score    <= '0;
         health   <= HEALTH_INIT;
         new_game <= 1'b0;
      end else begin
         state_q  <= state_d;
         angle    <= angle_d;
         weapon   <= weapon_d;
         score    <= score_d;
         health   <= health_d;
         new_game <= new_game_d;
      end
   end

   assign game_state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with DEBOUNCE_CYCLES=4.
// A transaction-level model (one update per press/pulse) predicts the
// packed output vector {game_state, angle, weapon, score, health}.
module tb_game_controller;

   localparam int DB   = 4;
   localparam int MAXH = 3;
   localparam int NW   = 3;
   localparam int SMAX = 99999;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Weapon_switch;
   logic        Rotate_CW;
   logic        Rotate_CCW;
   logic        Interaction;
   logic        hit_valid;
   logic [7:0]  hit_points;
   logic        damage_valid;
   logic [1:0]  game_state;
   logic [3:0]  angle;
   logic [1:0]  weapon;
   logic [17:0] score;
   logic [2:0]  health;
   logic        new_game;

   int vectors     = 0;
   int miscompares = 0;
   int ng_count    = 0;

   int m_state, m_angle, m_weapon, m_score, m_health;

   logic [28:0] dut_vec;
   assign dut_vec = {game_state, angle, weapon, score, health};

   game_controller #(
      .DEBOUNCE_CYCLES(DB), .MAX_HEALTH(MAXH), .NUM_WEAPONS(NW), .SCORE_MAX(SMAX)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .Weapon_switch(Weapon_switch), .Rotate_CW(Rotate_CW),
      .Rotate_CCW(Rotate_CCW), .Interaction(Interaction),
      .hit_valid(hit_valid), .hit_points(hit_points), .damage_valid(damage_valid),
      .game_state(game_state), .angle(angle), .weapon(weapon),
      .score(score), .health(health), .new_game(new_game)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (new_game) ng_count <= ng_count + 1;

   // ---------------- reference model ----------------
   function automatic logic [28:0] model_vec();
      return {2'(m_state), 4'(m_angle), 2'(m_weapon), 18'(m_score), 3'(m_health)};
   endfunction

   function automatic void m_reset();
      m_state = 0; m_angle = 0; m_weapon = 0; m_score = 0; m_health = MAXH;
   endfunction

   function automatic void m_start();
      m_state = 1; m_angle = 0; m_weapon = 0; m_score = 0; m_health = MAXH;
   endfunction

   // b: 0=weapon 1=cw 2=ccw 3=interaction
   function automatic void m_button(int b);
      if (m_state == 1) begin
         if (b == 0) m_weapon = (m_weapon + 1) % NW;
         if (b == 1) m_angle = (m_angle + 1) % 16;
         if (b == 2) m_angle = (m_angle + 15) % 16;
      end else if (b == 3) begin
         m_start();
      end
   endfunction

   function automatic void m_pulse(bit h, int pts, bit d);
      if (m_state == 1) begin
         if (h) m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
         if (d && m_health > 0) m_health = m_health - 1;
         if (m_health == 0) m_state = 2;
      end
   endfunction

   // ---------------- stimulus ----------------
   task automatic set_btn(int b, logic v);
      case (b)
         0: Weapon_switch = v;
         1: Rotate_CW = v;
         2: Rotate_CCW = v;
         default: Interaction = v;
      endcase
   endtask

   task automatic press_btn(int b, int hold);
      @(negedge CLK);
      set_btn(b, 1'b0);
      repeat (hold) @(negedge CLK);
      set_btn(b, 1'b1);
      repeat (12) @(negedge CLK);
      m_button(b);
   endtask

   task automatic pulse(bit h, int pts, bit d);
      @(negedge CLK);
      hit_valid = h; hit_points = 8'(pts); damage_valid = d;
      @(negedge CLK);
      hit_valid = 1'b0; hit_points = 8'd0; damage_valid = 1'b0;
      repeat (2) @(negedge CLK);
      m_pulse(h, pts, d);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET = 1'b0;
      Weapon_switch = 1'b1; Rotate_CW = 1'b1; Rotate_CCW = 1'b1; Interaction = 1'b1;
      hit_valid = 1'b0; hit_points = 8'd0; damage_valid = 1'b0;
      m_reset();
      repeat (3) @(negedge CLK);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", dut_vec, model_vec());
      end
      vectors++;
      if (new_game !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_new_game: got %b want 0", new_game);
      end
      RESET = 1'b1;
      repeat (4) @(negedge CLK);
      vectors++;
      if (ng_count !== 0 || dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL after_release: got %h ng=%0d want %h ng=0", dut_vec, ng_count, model_vec());
      end
   endtask

   task automatic test_title_ignore();
      pulse(1'b1, 100, 1'b1);
      press_btn(1, 10);
      press_btn(2, 10);
      press_btn(0, 10);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL title_ignore: got %h want %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_start();
      int ng0;
      ng0 = ng_count;
      press_btn(3, 10);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL start_play: got %h want %h", dut_vec, model_vec());
      end
      vectors++;
      if (ng_count - ng0 !== 1) begin
         miscompares++;
         $display("FAIL start_new_game_pulses: got %0d want 1", ng_count - ng0);
      end
   endtask

   task automatic test_rotate();
      int ng0;
      press_btn(2, 10);
      vectors++;
      if (dut_vec !== model_vec() || angle !== 4'd15) begin
         miscompares++;
         $display("FAIL rotate_ccw_wrap: got %h want %h", dut_vec, model_vec());
      end
      press_btn(1, 9);
      press_btn(1, 11);
      vectors++;
      if (dut_vec !== model_vec() || angle !== 4'd1) begin
         miscompares++;
         $display("FAIL rotate_cw_twice: got %h want %h", dut_vec, model_vec());
      end
      @(negedge CLK);
      Rotate_CW = 1'b0; Rotate_CCW = 1'b0;
      repeat (10) @(negedge CLK);
      Rotate_CW = 1'b1; Rotate_CCW = 1'b1;
      repeat (12) @(negedge CLK);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL rotate_both: got %h want %h", dut_vec, model_vec());
      end
      ng0 = ng_count;
      press_btn(3, 10);
      m_start(); m_state = 1;
      vectors++;
      if (ng_count !== ng0 || angle !== 4'd1) begin
         miscompares++;
         $display("FAIL play_interaction_ignored: got ng=%0d angle=%0d want ng=%0d angle=1", ng_count, angle, ng0);
      end
      m_angle = 1;
   endtask

   task automatic test_weapon_bounce();
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         Weapon_switch = (i % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge CLK);
      end
      @(negedge CLK);
      Weapon_switch = 1'b0;
      repeat (30) @(negedge CLK);
      Weapon_switch = 1'b1;
      repeat (12) @(negedge CLK);
      m_button(0);
      vectors++;
      if (dut_vec !== model_vec() || weapon !== 2'd1) begin
         miscompares++;
         $display("FAIL weapon_bounce: got %h want %h", dut_vec, model_vec());
      end
      for (int i = 0; i < 3; i++) begin
         press_btn(0, 8 + i);
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++;
            $display("FAIL weapon_step%0d: got %h want %h", i, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_damage_over();
      int s0, ng0;
      for (int i = 0; i < 4; i++) pulse(1'b1, $urandom_range(1, 255), 1'b0);
      pulse(1'b0, 0, 1'b1);
      pulse(1'b0, 0, 1'b1);
      vectors++;
      if (dut_vec !== model_vec() || health !== 3'd1) begin
         miscompares++;
         $display("FAIL damage_two: got %h want %h", dut_vec, model_vec());
      end
      s0 = m_score;
      pulse(1'b1, 10, 1'b1);
      vectors++;
      if (dut_vec !== model_vec() || score !== 18'(s0 + 10) || game_state !== 2'd2) begin
         miscompares++;
         $display("FAIL final_hit_and_damage: got %h want %h", dut_vec, model_vec());
      end
      press_btn(1, 10);
      press_btn(0, 10);
      pulse(1'b1, 77, 1'b1);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL over_frozen: got %h want %h", dut_vec, model_vec());
      end
      ng0 = ng_count;
      press_btn(3, 10);
      vectors++;
      if (dut_vec !== model_vec() || ng_count - ng0 !== 1) begin
         miscompares++;
         $display("FAIL try_again: got %h ng=%0d want %h ng=1", dut_vec, ng_count - ng0, model_vec());
      end
   endtask

   task automatic test_score_sat();
      int pts;
      @(negedge CLK);
      while (m_score < 99990 - 255) begin
         pts = $urandom_range(1, 255);
         hit_valid = 1'b1; hit_points = 8'(pts);
         m_pulse(1'b1, pts, 1'b0);
         @(negedge CLK);
      end
      hit_valid = 1'b0; hit_points = 8'd0;
      repeat (2) @(negedge CLK);
      if (m_score < 99990) pulse(1'b1, 99990 - m_score, 1'b0);
      vectors++;
      if (dut_vec !== model_vec() || score !== 18'd99990) begin
         miscompares++;
         $display("FAIL score_99990: got %h want %h", dut_vec, model_vec());
      end
      pulse(1'b1, 50, 1'b0);
      vectors++;
      if (score !== 18'd99999) begin
         miscompares++;
         $display("FAIL score_sat50: got %0d want 99999", score);
      end
      pulse(1'b1, 1, 1'b0);
      vectors++;
      if (dut_vec !== model_vec() || score !== 18'd99999) begin
         miscompares++;
         $display("FAIL score_sat1: got %h want %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_random();
      int kind;
      for (int i = 0; i < 50; i++) begin
         kind = $urandom_range(0, 5);
         if (kind <= 3) press_btn(kind, $urandom_range(8, 12));
         else if (kind == 4) pulse(1'b1, $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
         else pulse(1'b0, 0, 1'b1);
         vectors++;
         if (dut_vec !== model_vec()) begin
            miscompares++;
            $display("FAIL random_%0d kind=%0d: got %h want %h", i, kind, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_reset_midgame();
      if (m_state == 0) press_btn(3, 10);
      for (int i = 0; i < MAXH && m_state == 1; i++) pulse(1'b0, 0, 1'b1);
      press_btn(3, 10);
      pulse(1'b1, 250, 1'b0);
      pulse(1'b1, 250, 1'b0);
      vectors++;
      if (dut_vec !== model_vec() || score !== 18'd500) begin
         miscompares++;
         $display("FAIL pre_reset_score: got %h want %h", dut_vec, model_vec());
      end
      // leave an Interaction half-debounced when reset hits
      @(negedge CLK);
      Interaction = 1'b0;
      repeat (4) @(negedge CLK);
      #2 RESET = 1'b0;
      #1;
      m_reset();
      vectors++;
      if (dut_vec !== model_vec() || new_game !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got %h ng=%b want %h ng=0", dut_vec, new_game, model_vec());
      end
      @(negedge CLK);
      Interaction = 1'b1;
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      repeat (15) @(negedge CLK);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL no_pending_event: got %h want %h", dut_vec, model_vec());
      end
      press_btn(3, 10);
      vectors++;
      if (dut_vec !== model_vec()) begin
         miscompares++;
         $display("FAIL restart_after_reset: got %h want %h", dut_vec, model_vec());
      end
   endtask

   initial begin
      test_reset();
      test_title_ignore();
      test_start();
      test_rotate();
      test_weapon_bounce();
      test_damage_over();
      test_score_sat();
      test_random();
      test_reset_midgame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have these parameters: DEBOUNCE_CYCLES, default 250000, minimum stable cycles before a debounced button changes; MAX_HEALTH, default 3, health loaded at game start; NUM_WEAPONS, default 3, number of selectable weapons; SCORE_MAX, default 99999, score saturation value.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- CLK  in  1  system clock, 25.175 MHz pixel clock.
- RESET  in  1  asynchronous, active-low reset.
- Weapon_switch  in  1  raw button 3, active-low.
- Rotate_CW  in  1  raw button 2, active-low.
- Rotate_CCW  in  1  raw button 1, active-low.
- Interaction  in  1  raw button 4, active-low ("OKAY" / "Try again").
- hit_valid  in  1  one-cycle pulse: an enemy was destroyed.
- hit_points  in  8  points for that hit, unsigned.
- damage_valid  in  1  one-cycle pulse: the player was struck.
- game_state  out  2  0=TITLE, 1=PLAY, 2=OVER.
- angle  out  4  aim direction in 22.5-degree steps; 0 is up; value increases clockwise.
- weapon  out  2  current weapon index.
- score  out  18  binary score, at most SCORE_MAX.
- health  out  3  remaining health.
- new_game  out  1  one-cycle pulse on every entry to PLAY.

Function
REQ-003 Each raw button SHALL be synchronised through two flip-flops, then debounced: the debounced level SHALL change only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-004 A press event SHALL be a single-cycle pulse generated on the debounced 1-to-0 transition; a held button SHALL generate exactly one event.
REQ-005 Worst-case latency from a stable raw press to its effect on the outputs SHALL be 2 + DEBOUNCE_CYCLES + 2 cycles.
REQ-006 From TITLE, an Interaction event SHALL move the block to PLAY.
REQ-007 Entry to PLAY SHALL, in the same cycle, load score=0, health=MAX_HEALTH, angle=0 and weapon=0, and pulse new_game.
REQ-008 In PLAY, a Rotate_CW event SHALL set angle to angle+1 mod 16, and a Rotate_CCW event SHALL set angle to angle-1 mod 16 (15+1 gives 0; 0-1 gives 15).
REQ-009 If Rotate_CW and Rotate_CCW events occur in the same cycle, angle SHALL be unchanged.
REQ-010 In PLAY, a Weapon_switch event SHALL advance weapon cyclically: 0 to 1, then on to NUM_WEAPONS-1, then back to 0.
REQ-011 In PLAY, hit_valid SHALL set score to min(score + hit_points, SCORE_MAX), computed at 19-bit width so the addition cannot overflow.
REQ-012 In PLAY, damage_valid SHALL decrement health.
REQ-013 When health goes from 1 to 0, the block SHALL enter OVER in the next cycle; health SHALL never wrap below 0.
REQ-014 If hit_valid and the final damage_valid occur in the same cycle, the score SHALL still be updated before the block enters OVER.
REQ-015 In OVER, score, angle and weapon SHALL hold their values; rotation, weapon, hit and damage inputs SHALL be ignored.
REQ-016 From OVER, an Interaction event SHALL move the block to PLAY (try again) and apply REQ-007.
REQ-017 In TITLE, every input other than Interaction SHALL be ignored.
REQ-018 In PLAY, Interaction SHALL have no effect.
REQ-019 The unused game_state encoding 3 SHALL recover to TITLE in the next cycle.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 While RESET=0, the block SHALL asynchronously force game_state=TITLE, angle=0, weapon=0, score=0, health=MAX_HEALTH and new_game=0, and SHALL clear all debounce counters and synchronisers to the released (1) level.
REQ-022 An assertion of RESET mid-game SHALL abort the game with no pending event surviving, and the first cycle after release SHALL emit no press event.

Structure
REQ-023 The state encodings (TITLE, PLAY, OVER), ANGLE_W=4 and SCORE_W=18 SHALL be defined in the shared package game_pkg.
REQ-024 Debouncing and edge detection SHALL be implemented in one sub-module, button_debouncer (ports: CLK, RESET, btn_n, press), instantiated four times.
REQ-025 The score output SHALL remain binary; BCD digit conversion stays in the existing score display path.

Verification (use DEBOUNCE_CYCLES=4 in simulation)
REQ-026 Reset, then an Interaction press held 10 cycles -> game_state=1, a single new_game pulse, score=0, health=3.
REQ-027 In PLAY, press Rotate_CCW once from angle=0 -> angle=15; then press Rotate_CW twice -> angle=1; press both in the same cycle -> angle unchanged.
REQ-028 Bounce Weapon_switch 0/1 every 2 cycles for 20 cycles, then hold it low -> exactly one event and weapon=1; press three more times -> weapon steps 2, 0, 1.
REQ-029 With score=99990, a hit_valid with hit_points=50 -> score=99999; a further hit_valid with hit_points=1 -> score=99999.
REQ-030 Apply three damage_valid pulses, the last together with hit_valid and hit_points=10 -> score increases by 10, health=0, game_state=2; then press Interaction -> game_state=1, score=0, health=3.
REQ-031 Drive RESET low while in PLAY with score=500 -> all outputs at their reset values immediately, without waiting for a clock edge.
